// File: rtl/operand_bypass_net.sv
// Operand bypass and load-use hazard unit.
// Tracks in-flight register writers from EX through WB and resolves each read
// port to the youngest producer's result, or to the register file when no
// in-flight instruction writes that register.
module operand_bypass_net #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NPORTS   = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 1,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_we,
    input  logic [ADDR_W-1:0]          issue_waddr,
    input  logic                       issue_load,
    input  logic                       flush,
    input  logic [NPORTS*ADDR_W-1:0]   rd_addr,
    input  logic [NPORTS*DATA_W-1:0]   rf_data,
    input  logic [DEPTH*DATA_W-1:0]    stage_data,
    output logic [NPORTS*DATA_W-1:0]   op_data,
    output logic [NPORTS*SEL_W-1:0]    fwd_sel,
    output logic                       stall,
    output logic [CNT_W-1:0]           stall_count
);

    // Tag pipeline: index 0 is the instruction now in EX.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  load_q, load_d;
    logic [ADDR_W-1:0] waddr_q [DEPTH];
    logic [ADDR_W-1:0] waddr_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NPORTS-1:0] port_haz;

    // A stalled or flushed ID instruction enters EX as a bubble; older entries
    // always advance because they are already committed.
    always_comb begin
        valid_d[0] = issue_valid & issue_we & (issue_waddr != '0) & ~stall & ~flush;
        load_d[0]  = issue_load;
        waddr_d[0] = issue_waddr;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            load_d[i]  = load_q[i-1];
            waddr_d[i] = waddr_q[i-1];
        end
    end

    // Per-port producer match; the youngest matching entry wins.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [ADDR_W-1:0] addr;
            logic              hit;
            logic              hit_haz;
            logic [SEL_W-1:0]  hit_sel;
            logic [DATA_W-1:0] hit_data;
            logic [DATA_W-1:0] op_val;
            logic [SEL_W-1:0]  sel_val;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

            // Scan oldest to youngest so the lowest matching index is kept last.
            always_comb begin
                hit      = 1'b0;
                hit_haz  = 1'b0;
                hit_sel  = '0;
                hit_data = '0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (valid_q[i] && (waddr_q[i] == addr) && (addr != '0)) begin
                        hit      = 1'b1;
                        hit_haz  = load_q[i] && (i < LOAD_RDY);
                        hit_sel  = SEL_W'(i + 1);
                        hit_data = stage_data[i*DATA_W +: DATA_W];
                    end
                end
            end

            // r0 reads as zero; an unready load falls back to the register file
            // since the value is discarded while stalled anyway.
            always_comb begin
                op_val  = rf_data[gi*DATA_W +: DATA_W];
                sel_val = '0;
                if (addr == '0) begin
                    op_val = '0;
                end else if (hit && !hit_haz) begin
                    op_val  = hit_data;
                    sel_val = hit_sel;
                end
            end

            assign op_data[gi*DATA_W +: DATA_W] = op_val;
            assign fwd_sel[gi*SEL_W +: SEL_W]   = sel_val;
            assign port_haz[gi]                 = hit && hit_haz;
        end
    endgenerate

    assign stall = issue_valid & ~flush & (|port_haz);

    // Saturating stall counter; holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stall_count = cnt_q;

    // Tag and counter state registers; only valid bits need clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
        load_q  <= load_d;
        waddr_q <= waddr_d;
    end

endmodule

// File: tb/tb_operand_bypass_net.sv
// Self-checking bench for operand_bypass_net: directed scenarios plus random
// traffic compared against an issue-history model.
module tb_operand_bypass_net;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NPORTS   = 2;
    localparam int DEPTH    = 3;
    localparam int LOAD_RDY = 1;
    localparam int SEL_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      issue_valid, issue_we, issue_load, flush;
    logic [ADDR_W-1:0]         issue_waddr;
    logic [NPORTS*ADDR_W-1:0]  rd_addr;
    logic [NPORTS*DATA_W-1:0]  rf_data;
    logic [DEPTH*DATA_W-1:0]   stage_data;
    logic [NPORTS*DATA_W-1:0]  op_data, op_data2;
    logic [NPORTS*SEL_W-1:0]   fwd_sel, fwd_sel2;
    logic                      stall, stall2;
    logic [15:0]               stall_count;
    logic [1:0]                stall_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_bypass_net #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_waddr(issue_waddr), .issue_load(issue_load), .flush(flush),
        .rd_addr(rd_addr), .rf_data(rf_data), .stage_data(stage_data),
        .op_data(op_data), .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
    );

    operand_bypass_net #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_waddr(issue_waddr), .issue_load(issue_load), .flush(flush),
        .rd_addr(rd_addr), .rf_data(rf_data), .stage_data(stage_data),
        .op_data(op_data2), .fwd_sel(fwd_sel2), .stall(stall2), .stall_count(stall_count2)
    );

    // Reference model: newest-first history of what actually entered EX.
    typedef struct packed {
        bit              v;
        logic [ADDR_W-1:0] a;
        bit              ld;
    } rec_t;
    rec_t        hist[$];
    int unsigned mcount;

    function automatic void mdl_port(input logic [ADDR_W-1:0] a, output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (a == 0) return;
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k].v && hist[k].a == a) begin
                if (hist[k].ld && k < LOAD_RDY) haz = 1'b1;
                else sel = k + 1;
                return;
            end
        end
    endfunction

    function automatic bit mdl_stall();
        bit h = 1'b0;
        int s;
        bit hz;
        for (int p = 0; p < NPORTS; p++) begin
            mdl_port(rd_addr[p*ADDR_W +: ADDR_W], s, hz);
            h |= hz;
        end
        return issue_valid && !flush && h;
    endfunction

    function automatic int mdl_sel(input int p);
        int s;
        bit hz;
        mdl_port(rd_addr[p*ADDR_W +: ADDR_W], s, hz);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] mdl_op(input int p);
        int s = mdl_sel(p);
        if (rd_addr[p*ADDR_W +: ADDR_W] == 0) return '0;
        if (s == 0) return rf_data[p*DATA_W +: DATA_W];
        return stage_data[(s-1)*DATA_W +: DATA_W];
    endfunction

    function automatic int sat2(input int unsigned c);
        return (c > 3) ? 3 : int'(c);
    endfunction

    // Advance one clock, updating the model with what was presented this cycle.
    task automatic tick();
        bit   st = mdl_stall();
        rec_t r;
        r.v  = issue_valid && issue_we && (issue_waddr != 0) && !st && !flush;
        r.a  = issue_waddr;
        r.ld = issue_load;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            mcount = 0;
        end else begin
            hist.push_front(r);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            if (st && mcount < 65535) mcount++;
        end
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_we = 0; issue_load = 0; issue_waddr = '0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rd_addr = {5'd2, 5'd1};
        rf_data = {32'h22, 32'h11};
        #1;
        checks++;
        if (op_data !== {32'h22, 32'h11}) begin
            errors++; $display("FAIL reset_op got=%h exp=%h", op_data, {32'h22, 32'h11});
        end
        checks++;
        if (fwd_sel !== '0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_sel_stall got sel=%h stall=%b exp 0/0", fwd_sel, stall);
        end
        checks++;
        if (stall_count !== 16'd0 || stall_count2 !== 2'd0) begin
            errors++; $display("FAIL reset_count got=%0d/%0d exp=0/0", stall_count, stall_count2);
        end
        $display("test_reset done");
    endtask

    task automatic test_alu_forward();
        issue_valid = 1; issue_we = 1; issue_waddr = 5'd3; issue_load = 0;
        rd_addr = {5'd1, 5'd2};
        tick();
        idle();
        rd_addr = {5'd1, 5'd3};
        stage_data = {32'h0, 32'h0, 32'hAA};
        #1;
        checks++;
        if (op_data[31:0] !== 32'hAA || fwd_sel[1:0] !== 2'd1) begin
            errors++; $display("FAIL alu_ex got op=%h sel=%0d exp op=aa sel=1", op_data[31:0], fwd_sel[1:0]);
        end
        tick();
        stage_data = {32'h0, 32'hBB, 32'h0};
        #1;
        checks++;
        if (op_data[31:0] !== 32'hBB || fwd_sel[1:0] !== 2'd2) begin
            errors++; $display("FAIL alu_mem got op=%h sel=%0d exp op=bb sel=2", op_data[31:0], fwd_sel[1:0]);
        end
        $display("test_alu_forward done");
    endtask

    task automatic test_youngest_wins();
        issue_valid = 1; issue_we = 1; issue_waddr = 5'd4; issue_load = 0;
        rd_addr = '0;
        tick();
        tick();
        idle();
        rd_addr = {5'd4, 5'd0};
        stage_data = {32'h3, 32'h2, 32'h1};
        #1;
        checks++;
        if (op_data[63:32] !== 32'h1 || fwd_sel[3:2] !== 2'd1) begin
            errors++; $display("FAIL youngest got op=%h sel=%0d exp op=1 sel=1", op_data[63:32], fwd_sel[3:2]);
        end
        $display("test_youngest_wins done");
    endtask

    task automatic test_load_use();
        do_reset();
        issue_valid = 1; issue_we = 1; issue_load = 1; issue_waddr = 5'd5;
        rd_addr = '0;
        tick();
        issue_load = 0; issue_waddr = 5'd8;
        rd_addr = {5'd8, 5'd5};
        rf_data = {32'h77, 32'h66};
        stage_data = {32'h3, 32'hC2, 32'hC1};
        #1;
        checks++;
        if (stall !== 1'b1 || fwd_sel[1:0] !== 2'd0 || op_data[31:0] !== 32'h66) begin
            errors++; $display("FAIL load_use_stall got stall=%b sel=%0d op=%h exp 1/0/66", stall, fwd_sel[1:0], op_data[31:0]);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2 || op_data[31:0] !== 32'hC2) begin
            errors++; $display("FAIL load_use_fwd got stall=%b sel=%0d op=%h exp 0/2/c2", stall, fwd_sel[1:0], op_data[31:0]);
        end
        checks++;
        if (fwd_sel[3:2] !== 2'd0 || stall_count !== 16'd1) begin
            errors++; $display("FAIL load_use_bubble got sel1=%0d cnt=%0d exp 0/1", fwd_sel[3:2], stall_count);
        end
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel[3:2] !== 2'd1 || fwd_sel[1:0] !== 2'd3) begin
            errors++; $display("FAIL load_use_after got sel=%h exp sel1=1 sel0=3", fwd_sel);
        end
        $display("test_load_use done");
    endtask

    task automatic test_zero_and_flush();
        issue_valid = 1; issue_we = 1; issue_waddr = 5'd0; issue_load = 0;
        rd_addr = '0;
        tick();
        idle();
        rd_addr = {5'd0, 5'd0};
        stage_data = {32'h0, 32'h0, 32'hFF};
        rf_data = {32'h55, 32'h44};
        #1;
        checks++;
        if (op_data[31:0] !== 32'h0 || fwd_sel[1:0] !== 2'd0 || stall !== 1'b0) begin
            errors++; $display("FAIL zero_reg got op=%h sel=%0d stall=%b exp 0/0/0", op_data[31:0], fwd_sel[1:0], stall);
        end
        issue_valid = 1; issue_we = 1; issue_load = 1; issue_waddr = 5'd6;
        tick();
        issue_load = 0; issue_waddr = 5'd9; flush = 1;
        rd_addr = {5'd0, 5'd6};
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall got=%b exp=0", stall);
        end
        tick();
        idle();
        rd_addr = {5'd6, 5'd9};
        #1;
        checks++;
        if (fwd_sel[1:0] !== 2'd0 || fwd_sel[3:2] !== 2'd2) begin
            errors++; $display("FAIL flush_squash got sel=%h exp sel0=0 sel1=2", fwd_sel);
        end
        $display("test_zero_and_flush done");
    endtask

    task automatic test_random();
        for (int t = 0; t < 200; t++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_we    = ($urandom_range(0, 3) != 0);
            issue_load  = ($urandom_range(0, 2) == 0);
            issue_waddr = ADDR_W'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 9) == 0);
            rd_addr     = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
            rf_data     = {$urandom(), $urandom()};
            stage_data  = {$urandom(), $urandom(), $urandom()};
            #1;
            checks++;
            if (stall !== mdl_stall() || stall2 !== mdl_stall()) begin
                errors++; $display("FAIL rnd_stall t=%0d got=%b/%b exp=%b", t, stall, stall2, mdl_stall());
            end
            for (int p = 0; p < NPORTS; p++) begin
                checks++;
                if (op_data[p*DATA_W +: DATA_W] !== mdl_op(p) || op_data2[p*DATA_W +: DATA_W] !== mdl_op(p)) begin
                    errors++; $display("FAIL rnd_op t=%0d p=%0d got=%h exp=%h", t, p, op_data[p*DATA_W +: DATA_W], mdl_op(p));
                end
                checks++;
                if (int'(fwd_sel[p*SEL_W +: SEL_W]) != mdl_sel(p) || int'(fwd_sel2[p*SEL_W +: SEL_W]) != mdl_sel(p)) begin
                    errors++; $display("FAIL rnd_sel t=%0d p=%0d got=%0d exp=%0d", t, p, fwd_sel[p*SEL_W +: SEL_W], mdl_sel(p));
                end
            end
            checks++;
            if (int'(stall_count) != int'(mcount) || int'(stall_count2) != sat2(mcount)) begin
                errors++; $display("FAIL rnd_count t=%0d got=%0d/%0d exp=%0d/%0d", t, stall_count, stall_count2, mcount, sat2(mcount));
            end
            $display("txn %0d rd=%h stall=%b sel=%h cnt=%0d", t, rd_addr, stall, fwd_sel, stall_count);
            tick();
        end
    endtask

    task automatic test_saturate_and_rst();
        do_reset();
        issue_valid = 1; issue_we = 1; issue_load = 1; issue_waddr = 5'd7;
        rd_addr = {5'd0, 5'd7};
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if (stall_count !== 16'd5 || stall_count2 !== 2'd3) begin
            errors++; $display("FAIL saturate got=%0d/%0d exp=5/3", stall_count, stall_count2);
        end
        tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL mid_stall got=%b exp=1", stall);
        end
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || stall_count !== 16'd0 || stall_count2 !== 2'd0) begin
            errors++; $display("FAIL rst_mid_stall got stall=%b cnt=%0d/%0d exp 0/0/0", stall, stall_count, stall_count2);
        end
        $display("test_saturate_and_rst done");
    endtask

    initial begin
        rst = 1;
        idle();
        rd_addr = '0;
        rf_data = '0;
        stage_data = '0;
        mcount = 0;
        test_reset();
        test_alu_forward();
        test_youngest_wins();
        test_load_use();
        test_zero_and_flush();
        test_random();
        test_saturate_and_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
